// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/sequencing stage:
// opcode encodings, shift/legality helpers and the sequencer state type.
package alu_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = 5;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SLA = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift opcodes are the ones executed as a chain of single-bit ALU steps.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLA) || (op == OP_SRA) || (op == OP_SRL);
  endfunction

  // Encodings above OP_SRL have no ALU meaning; the sequencer returns 0 for them.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SRL;
  endfunction

endpackage

// File: rtl/alu_shift_sequencer.sv
// Issue/sequencing stage in front of the ALU. Accepts one operation per
// handshake, drives the ALU from registered state, and realises multi-bit
// shifts by feeding the ALU result back as A with a 1-bit shift each cycle.
module alu_shift_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = alu_pkg::DATA_WIDTH,
  parameter int SHAMT_WIDTH = alu_pkg::SHAMT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_opcode,
  input  logic [DATA_WIDTH-1:0]  in_a,
  input  logic [DATA_WIDTH-1:0]  in_b,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  output logic [3:0]             alu_opcode,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic                   alu_shift_amount,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_result,
  output logic                   busy
);

  state_t                 state_q, state_d;
  logic [3:0]             op_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic [SHAMT_WIDTH-1:0] rem_q;

  logic accept;
  logic last_step;

  assign accept    = in_valid && in_ready;
  // Non-shifts finish after one EXEC cycle; shifts finish on the step that
  // consumes the last remaining bit (or immediately for a zero count).
  assign last_step = !is_shift(op_q) || (rem_q <= SHAMT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting state_d before the case keeps every path assigned,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready         = (state_q == IDLE) && !rst;
    out_valid        = (state_q == DONE);
    busy             = (state_q != IDLE);
    alu_shift_amount = (state_q == EXEC) && is_shift(op_q) && (rem_q != '0);
  end

  // Operand capture and the iterate-through-the-ALU accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      acc_q <= '0;
      b_q   <= '0;
      rem_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= in_opcode;
            acc_q <= in_a;
            b_q   <= in_b;
            rem_q <= is_shift(in_opcode) ? in_shamt : '0;
          end
        end
        EXEC: begin
          // The ALU output for an undefined opcode is not trusted.
          acc_q <= is_legal(op_q) ? alu_result : '0;
          if (rem_q != '0) rem_q <= rem_q - SHAMT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // ALU inputs come straight from registers: no combinational in_* -> alu_* path.
  assign alu_opcode = op_q;
  assign alu_a      = acc_q;
  assign alu_b      = b_q;

  // Result is presented only while valid and is held until the consumer takes it.
  assign out_result = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer: a behavioural single-step ALU
// closes the loop, and a queue holds the expected final result per request.
module tb_alu_shift_sequencer;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_a, in_b;
  logic [SW-1:0] in_shamt;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_shift_amount;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  alu_shift_sequencer #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shift_amount(alu_shift_amount), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-step ALU; illegal opcodes yield a marker that must never surface.
  always_comb begin
    alu_result = 32'hBAD0_BAD0;
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = ~alu_a;
      4'b0110: begin
        alu_result = alu_a;
        if (alu_shift_amount) alu_result = alu_a << 1;
      end
      4'b0111: begin
        alu_result = alu_a;
        if (alu_shift_amount) alu_result = $signed(alu_a) >>> 1;
      end
      4'b1000: begin
        alu_result = alu_a;
        if (alu_shift_amount) alu_result = alu_a >> 1;
      end
      default: ;
    endcase
  end

  function automatic logic tb_shift(input logic [3:0] op);
    return (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
  endfunction

  // Whole-operation reference: shifts are computed in one go, not iterated.
  function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [SW-1:0] sh);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: r = $signed(a) >>> sh;
      4'd8: r = a >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one op, check latency and shift pulses, hold off the consumer for
  // 'hold' cycles, then drain and check the return to IDLE.
  task automatic run_op(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [SW-1:0] sh, input int hold);
    int n, shifts, exp_lat, exp_shifts;
    logic [DW-1:0] exp;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout in_ready=%b want 1", name, in_ready);
      return;
    end
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_shamt = sh;
    @(posedge clk);
    exp_q.push_back(ref_result(op, a, b, sh));
    #1;
    in_valid = 1'b0;
    in_opcode = 4'($urandom); in_a = $urandom; in_b = $urandom; in_shamt = SW'($urandom);
    exp_lat    = (tb_shift(op) && sh > 1) ? int'(sh) : 1;
    exp_shifts = tb_shift(op) ? int'(sh) : 0;
    n = 0; shifts = 0;
    while (!out_valid && n < 100) begin
      if (alu_shift_amount) shifts++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s done_timeout out_valid=%b want 1", name, out_valid);
      void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (n != exp_lat) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", name, n, exp_lat);
    end
    checks++;
    if (shifts != exp_shifts) begin
      failures++; $display("FAIL %s shift_pulses got=%0d want=%0d", name, shifts, exp_shifts);
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp_q[0]) begin
        failures++;
        $display("FAIL %s hold%0d valid=%b ready=%b result=%h want 1/0/%h",
                 name, i, out_valid, in_ready, out_result, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (out_result !== exp) begin
      failures++; $display("FAIL %s result got=%h want=%h", name, out_result, exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s drain valid=%b busy=%b ready=%b want 0/0/1", name, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== '0 ||
        alu_shift_amount !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_opcode !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b valid=%b ready=%b res=%h sa=%b a=%h b=%h op=%h want all 0",
               busy, out_valid, in_ready, out_result, alu_shift_amount, alu_a, alu_b, alu_opcode);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_arith();
    run_op("add",      OP_ADD, 32'd5,         32'd7,         5'd0, 0);
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2,         5'd9, 0);
    run_op("and",      OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3, 0);
    run_op("or",       OP_OR,  32'hF000_0001, 32'h0000_0F10, 5'd0, 0);
    run_op("xor",      OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 0);
    run_op("not",      OP_NOT, 32'h1234_5678, 32'd0,         5'd0, 0);
  endtask

  task automatic test_shifts();
    run_op("sla_4",    OP_SLA, 32'h0000_0001, 32'd0, 5'd4,  0);
    run_op("sla_0",    OP_SLA, 32'hDEAD_BEEF, 32'd0, 5'd0,  0);
    run_op("sla_31",   OP_SLA, 32'h0000_0001, 32'd0, 5'd31, 0);
    run_op("srl_4",    OP_SRL, 32'h8000_0000, 32'd0, 5'd4,  0);
    run_op("sra_4",    OP_SRA, 32'h8000_0000, 32'd0, 5'd4,  0);
    run_op("sra_1",    OP_SRA, 32'h8000_0001, 32'd0, 5'd1,  0);
  endtask

  task automatic test_illegal();
    run_op("ill_1111", 4'b1111, 32'h1234_5678, 32'h1, 5'd6, 0);
    run_op("ill_1001", 4'b1001, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
  endtask

  task automatic test_backpressure();
    run_op("sub_bp", OP_SUB, 32'd10, 32'd3, 5'd0, 3);
    run_op("srl_bp", OP_SRL, 32'hF000_0000, 32'd0, 5'd2, 2);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_opcode = OP_SLA; in_a = 32'd1; in_b = 32'd0; in_shamt = 5'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_shift_amount !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_exec sa=%b busy=%b want 1/1", alu_shift_amount, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_ready in_ready=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || alu_shift_amount !== 1'b0 || out_result !== '0) begin
      failures++;
      $display("FAIL rst_mid_state busy=%b valid=%b sa=%b res=%h want 0/0/0/0",
               busy, out_valid, alu_shift_amount, out_result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_release in_ready=%b want 1", in_ready);
    end
    run_op("add_after_rst", OP_ADD, 32'd1, 32'd1, 5'd0, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int i = 0; i < 8; i++) begin
      op = (i == 7) ? 4'b1100 : 4'($urandom_range(0, 8));
      run_op($sformatf("b2b%0d", i), op, $urandom, $urandom, SW'($urandom_range(0, 12)), i % 2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_shamt = '0;
    out_ready = 1'b0;
    test_reset();
    test_arith();
    test_shifts();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover size=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
Issue/sequencing stage that sits directly upstream of the ALU and also consumes the ALU result. It accepts one operation per valid/ready handshake and drives the ALU's opcode, A, B and 1-bit shift_amount inputs. Multi-bit shifts (0..31) are executed by repeatedly feeding ALU_result back as A with shift_amount=1. The final result is returned on a valid/ready output port.

Parameters:
DATA_WIDTH, 32, operand/result width (must match ALU)
SHAMT_WIDTH, 5, shift-count width; max shift = 2**SHAMT_WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready at posedge clk
in_opcode  in  4  ALU opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SLA, 0111 SRA, 1000 SRL
in_a  in  DATA_WIDTH  operand A
in_b  in  DATA_WIDTH  operand B
in_shamt  in  SHAMT_WIDTH  shift count; ignored for non-shift opcodes
alu_opcode  out  4  to ALU opcode
alu_a  out  DATA_WIDTH  to ALU A
alu_b  out  DATA_WIDTH  to ALU B
alu_shift_amount  out  1  to ALU shift_amount
alu_result  in  DATA_WIDTH  from ALU_result (combinational, same cycle)
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_result  out  DATA_WIDTH  final result
busy  out  1  state != IDLE

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high. On reset: state=IDLE; op_q, acc_q, b_q, rem_q cleared to 0; out_valid=0; out_result=0; busy=0. in_ready=0 while rst=1.
- alu_opcode=op_q, alu_a=acc_q, alu_b=b_q. These are registered; no combinational path from in_* to alu_*.
- alu_shift_amount=1 only when state=EXEC, op_q is a shift, and rem_q!=0. Otherwise 0.
- FSM states:
  - IDLE: in_ready=1. On handshake: op_q<=in_opcode, acc_q<=in_a, b_q<=in_b. rem_q<=in_shamt for shift opcodes, else 0. Go to EXEC.
  - EXEC: one cycle per step; acc_q<=alu_result each cycle.
    - Shift with rem_q>1: rem_q--, stay in EXEC.
    - Shift with rem_q<=1, or non-shift: go to DONE.
    - Shift with rem_q=0: one EXEC cycle with alu_shift_amount=0, so the result is A unchanged.
  - DONE: out_valid=1, out_result=acc_q (stable). On out_ready: go to IDLE, out_valid deasserts next cycle.
- Illegal opcode (1001..1111): one EXEC cycle, acc_q<=0, result 0 returned. The ALU output is not used.
- Latency: accept edge k; out_valid rises at edge k+N, where N = max(1, shamt) for shifts and N=1 otherwise. Minimum throughput is one op per N+2 cycles.
- Only one op is in flight; in_ready=0 in EXEC and DONE.
- in_* values change after acceptance have no effect.
- out_ready held low in DONE: out_valid and out_result stay held indefinitely.
- Fill semantics of each shift are whatever the ALU produces for one step; the sequencer only iterates.
- rst mid-EXEC or mid-DONE: the op is abandoned, no output is produced, and state is IDLE on the next cycle.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD..OP_SRL), is_shift function, FSM state encoding (IDLE/EXEC/DONE), DATA_WIDTH default.
- No sub-module needed. An integration wrapper alu_exec_unit (sequencer + ALU) is built separately for system-level tests.

Test Plan:
- ADD A=5, B=7 accepted at edge 0 -> out_valid at edge 1, out_result=12; alu_shift_amount never high.
- SLA A=0x00000001, shamt=4 -> alu_shift_amount high exactly 4 cycles; out_result=0x00000010 at edge 4.
- SLA A=0xDEADBEEF, shamt=0 -> one EXEC cycle with alu_shift_amount=0; out_result=0xDEADBEEF.
- SLA A=1, shamt=31 -> 31 EXEC cycles, out_result=0x80000000. Also SRL/SRA A=0x80000000, shamt=4 -> result equals 4 successive single-step ALU applications (reference model).
- Backpressure: SUB 10-3 with out_ready low for 3 cycles -> out_valid and out_result=7 held, in_ready=0; IDLE one cycle after out_ready.
- rst pulsed at 2nd EXEC cycle of SLA shamt=8 -> next cycle busy=0, out_valid=0, in_ready=1 after rst drops; next ADD 1+1 returns 2. Illegal opcode 1111 -> out_result=0.
